// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: D-cache miss freeze, load-use bubble, mispredict kill.
// Latency: control outputs are combinational from inputs and state; the counters update on the next edge.
// Backpressure: a D-cache miss freezes the whole pipe until the refill pulse; a kill raised during the freeze is replayed on the release cycle.
module pipe_hazard_ctrl #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr,
    input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr,
    input  logic                  EX_Mem_r,
    input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
    input  logic                  EX_Mispredict,
    input  logic                  DC_Req,
    input  logic                  DC_Hit,
    input  logic                  DC_Refill_Done,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Flush,
    output logic                  ID_EX_Stall,
    output logic                  EX_MEM_Stall,
    output logic [31:0]           Stall_Cycles,
    output logic [15:0]           Miss_Count
);

    typedef enum logic {RUN, MISS} state_t;

    state_t      state;
    logic        flush_pend;
    logic [31:0] stall_cycles_q;
    logic [15:0] miss_count_q;

    logic miss_start;
    logic d_stall;
    logic load_use;
    logic kill;

    assign miss_start = (state == RUN) && DC_Req && !DC_Hit;
    assign d_stall    = miss_start || ((state == MISS) && !DC_Refill_Done);
    assign load_use   = EX_Mem_r && (EX_Rd_Addr != '0) &&
                        ((EX_Rd_Addr == ID_Rs1_Addr) || (EX_Rd_Addr == ID_Rs2_Addr));
    // A pending flush fires only once the freeze lifts, merging with a still-high mispredict.
    assign kill       = (EX_Mispredict || flush_pend) && !d_stall;

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        ID_EX_Stall  = 1'b0;
        EX_MEM_Stall = 1'b0;
        if (d_stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Stall  = 1'b1;
            EX_MEM_Stall = 1'b1;
        end else if (kill) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            flush_pend     <= 1'b0;
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            case (state)
                RUN:     if (miss_start) state <= MISS;
                MISS:    if (DC_Refill_Done) state <= RUN;
                default: state <= RUN;
            endcase

            if (d_stall && EX_Mispredict)
                flush_pend <= 1'b1;
            else if (!d_stall)
                flush_pend <= 1'b0;

            if ((d_stall || (load_use && !kill)) && (stall_cycles_q != 32'hFFFF_FFFF))
                stall_cycles_q <= stall_cycles_q + 32'd1;

            if (miss_start && (miss_count_q != 16'hFFFF))
                miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign Stall_Cycles = stall_cycles_q;
    assign Miss_Count   = miss_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle scoreboard of a behavioural model plus directed scenarios.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_r, ex_mispred, dc_req, dc_hit, dc_done;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_stall;
    logic [31:0] stall_cycles;
    logic [15:0] miss_count;

    pipe_hazard_ctrl #(.ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_Rs1_Addr    (id_rs1),
        .ID_Rs2_Addr    (id_rs2),
        .EX_Mem_r       (ex_mem_r),
        .EX_Rd_Addr     (ex_rd),
        .EX_Mispredict  (ex_mispred),
        .DC_Req         (dc_req),
        .DC_Hit         (dc_hit),
        .DC_Refill_Done (dc_done),
        .PC_Write       (pc_write),
        .IF_ID_Write    (if_id_write),
        .IF_ID_Flush    (if_id_flush),
        .ID_EX_Flush    (id_ex_flush),
        .ID_EX_Stall    (id_ex_stall),
        .EX_MEM_Stall   (ex_mem_stall),
        .Stall_Cycles   (stall_cycles),
        .Miss_Count     (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Stall, EX_MEM_Stall}
    localparam logic [5:0] CTL_IDLE  = 6'b110000;
    localparam logic [5:0] CTL_STALL = 6'b000011;
    localparam logic [5:0] CTL_KILL  = 6'b111100;
    localparam logic [5:0] CTL_BUBL  = 6'b000100;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] sc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural reference state
    logic        m_miss;
    logic        m_pend;
    logic [31:0] m_stall;
    logic [15:0] m_mcnt;

    logic [31:0] base_sc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_ctl();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_stall, ex_mem_stall};
    endfunction

    task automatic model_reset();
        m_miss  = 1'b0;
        m_pend  = 1'b0;
        m_stall = '0;
        m_mcnt  = '0;
        sb_q.delete();
    endtask

    // One pipeline cycle: entered and left at a falling edge.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic mem_r,
                        input logic [4:0] rd, input logic mis, input logic req,
                        input logic hit, input logic done, input string tag);
        logic       ds, lu, kl;
        exp_t       e, got;
        logic [5:0] ctl_obs;
        id_rs1 = rs1; id_rs2 = rs2; ex_mem_r = mem_r; ex_rd = rd;
        ex_mispred = mis; dc_req = req; dc_hit = hit; dc_done = done;

        ds = m_miss ? !done : (req && !hit);
        lu = mem_r && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        kl = (mis || m_pend) && !ds;
        if (ds)      e.ctl = CTL_STALL;
        else if (kl) e.ctl = CTL_KILL;
        else if (lu) e.ctl = CTL_BUBL;
        else         e.ctl = CTL_IDLE;
        if ((ds || (lu && !kl)) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (!m_miss && req && !hit) begin
            m_miss = 1'b1;
            if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 1;
        end else if (m_miss && done) begin
            m_miss = 1'b0;
        end
        if (ds && mis)  m_pend = 1'b1;
        else if (!ds)   m_pend = 1'b0;
        e.sc = m_stall;
        e.mc = m_mcnt;
        sb_q.push_back(e);

        #1 ctl_obs = dut_ctl();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_eq({tag, "_ctl"}, {26'd0, ctl_obs}, {26'd0, got.ctl});
            check_eq({tag, "_stall_cycles"}, stall_cycles, got.sc);
            check_eq({tag, "_miss_count"}, {16'd0, miss_count}, {16'd0, got.mc});
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_mem_r = 1'b0; ex_mispred = 1'b0; dc_req = 1'b0; dc_hit = 1'b0; dc_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {26'd0, dut_ctl()}, {26'd0, CTL_IDLE});
        check_eq("rst_stall_cycles", stall_cycles, 32'd0);
        check_eq("rst_miss_count", {16'd0, miss_count}, 32'd0);
        rst_n = 1'b1;
        idle("post_rst");

        // Load-use on rs2 and rs1, then x0 destination never bubbles
        base_sc = stall_cycles;
        step(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rs2");
        check_eq("lu_rs2_delta", stall_cycles, base_sc + 32'd1);
        step(5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rs1");
        step(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_x0");
        step(5'd3, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, "lu_nomatch");
        step(5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, "lu_noload");

        // Cache hit and stray refill pulse in RUN
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, "hit");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "refill_in_run");

        // Miss: cycle 0 miss, cycles 1-3 frozen (req/hit ignored), release on cycle 4
        base_sc = stall_cycles;
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "miss_c0");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, "miss_c1");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "miss_c2");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "miss_c3");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "miss_c4");
        check_eq("miss_count_one", {16'd0, miss_count}, 32'd1);
        check_eq("miss_stall_delta", stall_cycles, base_sc + 32'd4);
        idle("miss_after");

        // Mispredict arriving at cycle 2 of a miss, held through release
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "mpm_c0");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "mpm_c1");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "mpm_c2");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "mpm_c3");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "mpm_c4");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "mpm_c5");

        // Mispredict pulse early in a miss, dropped before release: pending flag carries it
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, "pend_c0");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "pend_c1");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "pend_c2");
        idle("pend_c3");

        // Mispredict and load-use together: kill wins, no stall counted
        base_sc = stall_cycles;
        step(5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, "kill_lu");
        check_eq("kill_lu_delta", stall_cycles, base_sc);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) == 0), "rand");
        end
        for (int i = 0; i < 4; i++) step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "drain");

        // Stall counter saturation
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        m_stall = 32'hFFFF_FFFE;
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_c0");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_c1");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_c2");
        check_eq("sat_held", stall_cycles, 32'hFFFF_FFFF);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "sat_release");

        // Reset in the middle of a miss is asynchronous and abandons the miss
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "rmid_c0");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rmid_c1");
        rst_n = 1'b0;
        #1;
        check_eq("rmid_stall_cycles", stall_cycles, 32'd0);
        check_eq("rmid_miss_count", {16'd0, miss_count}, 32'd0);
        check_eq("rmid_ctl", {26'd0, dut_ctl()}, {26'd0, CTL_IDLE});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle("rmid_idle");
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "rmid_stray_done");
        idle("rmid_after");
        check_eq("rmid_final_stall", stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have `rst_n`, input, 1, asynchronous active-low reset.
REQ-003 SHALL have `ID_Rs1_Addr` and `ID_Rs2_Addr`, inputs, `ADDR_WIDTH` (5) each, source register numbers of the instruction in ID.
REQ-004 SHALL have `EX_Mem_r`, input, 1, load in EX; and `EX_Rd_Addr`, input, `ADDR_WIDTH`, its destination.
REQ-005 SHALL have `EX_Mispredict`, input, 1, branch/jump in EX resolved against its prediction.
REQ-006 SHALL have `DC_Req`, input, 1, valid D-cache access in MEM; `DC_Hit`, input, 1, lookup hit; `DC_Refill_Done`, input, 1, single-cycle refill-complete pulse.
REQ-007 SHALL have `PC_Write`, output, 1, PC update enable; and `IF_ID_Write`, output, 1, IF/ID load enable.
REQ-008 SHALL have `IF_ID_Flush` and `ID_EX_Flush`, outputs, 1 each, bubble insertion.
REQ-009 SHALL have `ID_EX_Stall` and `EX_MEM_Stall`, outputs, 1 each, register freeze.
REQ-010 SHALL have `Stall_Cycles`, output, 32, saturating stall counter; and `Miss_Count`, output, 16, saturating miss counter.

Function
REQ-011 SHALL implement FSM {RUN, MISS}; RUN->MISS when `DC_Req & !DC_Hit`; MISS->RUN when `DC_Refill_Done`; `DC_Req`/`DC_Hit` ignored in MISS.
REQ-012 SHALL compute `D_Stall` combinationally = `(RUN & DC_Req & !DC_Hit) | (MISS & !DC_Refill_Done)`: stall on the miss cycle, release on the refill cycle.
REQ-013 SHALL compute `Load_Use` = `EX_Mem_r & EX_Rd_Addr!=0 & (EX_Rd_Addr==ID_Rs1_Addr | EX_Rd_Addr==ID_Rs2_Addr)`.
REQ-014 SHALL hold a `Flush_Pend` flag: set when `EX_Mispredict & D_Stall`, cleared on any cycle with `!D_Stall`.
REQ-015 SHALL define `Kill` = `(EX_Mispredict | Flush_Pend) & !D_Stall`.
REQ-016 SHALL drive outputs by priority, all combinational:
- D_Stall: PC_Write=0, IF_ID_Write=0, ID_EX_Stall=1, EX_MEM_Stall=1, both flushes 0.
- else Kill: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, stalls 0.
- else Load_Use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0, stalls 0.
- else: PC_Write=1, IF_ID_Write=1, all flush/stall 0.
REQ-017 SHALL make Kill override Load_Use, because the ID instruction is discarded.
REQ-018 SHALL assert each Kill flush for exactly one cycle per mispredict event; `Flush_Pend` and a still-high `EX_Mispredict` on the release cycle together produce one flush, not two.
REQ-019 SHALL increment `Stall_Cycles` by 1 on each cycle with `D_Stall | (Load_Use & !Kill)`, saturating at 0xFFFFFFFF.
REQ-020 SHALL increment `Miss_Count` on each RUN->MISS transition, saturating at 0xFFFF.
REQ-021 SHALL treat `DC_Refill_Done` in RUN as a no-op.

Reset
REQ-022 SHALL, while `rst_n`=0, force state=RUN, Flush_Pend=0, Stall_Cycles=0, Miss_Count=0, irrespective of clk.
REQ-023 SHALL, after reset with all inputs 0, drive PC_Write=1, IF_ID_Write=1, all flush/stall 0.
REQ-024 SHALL, on reset asserted during MISS, abandon the miss immediately; a later stray `DC_Refill_Done` has no effect.

Verification
REQ-025 SHALL verify load-use: EX_Mem_r=1, EX_Rd_Addr=5, ID_Rs2_Addr=5 -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, Stall_Cycles +1; repeat with EX_Rd_Addr=0 -> no bubble.
REQ-026 SHALL verify a miss: DC_Req=1, DC_Hit=0 at cycle 0, DC_Refill_Done at cycle 4 -> ID_EX_Stall=EX_MEM_Stall=1 for cycles 0-3, 0 at cycle 4; Miss_Count=1, Stall_Cycles=4.
REQ-027 SHALL verify mispredict during a miss: EX_Mispredict=1 at cycle 2 of a miss -> no flush through cycle 3; IF_ID_Flush=ID_EX_Flush=1 on release cycle 4 only; 0 at cycle 5 once Mispredict drops.
REQ-028 SHALL verify mispredict with load-use in the same cycle -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1, Stall_Cycles unchanged.
REQ-029 SHALL verify saturation: preload Stall_Cycles to 0xFFFFFFFE via forced stalls, then 3 stall cycles -> 0xFFFFFFFF held.
REQ-030 SHALL verify reset mid-miss: rst_n low at miss cycle 2 -> outputs at idle values, counters 0, state RUN; a DC_Refill_Done pulse after reset causes no change.
